// File: rtl/top_level_nios2_qsys_0_oci_dct_ctrl.sv
// top_level_nios2_qsys_0_oci_dct_ctrl: packs trace items into 30-bit frames and writes them to trace memory
// Define DCT_NO_WRAP_EN to stop tracing once the last trace-memory address has been written.
module top_level_nios2_qsys_0_oci_dct_ctrl #(
    parameter int ITEM_W          = 10,
    parameter int ITEMS_PER_FRAME = 3,
    parameter int ADDR_W          = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trc_on,
    input  logic              item_valid,
    input  logic [ITEM_W-1:0] item_data,
    output logic              item_ready,
    input  logic              flush_req,
    input  logic              end_req,
    output logic              frm_valid,
    output logic [29:0]       frm_data,
    output logic [ADDR_W-1:0] frm_addr,
    input  logic              frm_ready,
    output logic              wrap,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              test_ending,
    output logic              test_has_ended
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] EMIT    = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] ENDED   = 3'd4;
    localparam logic [3:0] FULL = 4'(ITEMS_PER_FRAME);
    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [2:0]        state_q, state_d;
    logic [29:0]       buf_q, buf_d, buf_a;
    logic [3:0]        cnt_q, cnt_d, cnt_a;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              stop, acc, hs;

`ifdef DCT_NO_WRAP_EN
    assign stop = wrap_q;
`else
    assign stop = 1'b0;
`endif

    assign item_ready     = (state_q == COLLECT) & trc_on & (cnt_q < FULL) & !stop;
    assign frm_valid      = (state_q == EMIT) | ((state_q == DRAIN) & (cnt_q != 4'd0));
    assign acc            = item_valid & item_ready;
    assign hs             = frm_valid & frm_ready;
    assign frm_data       = buf_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign frm_addr       = addr_q;
    assign wrap           = wrap_q;
    assign test_ending    = state_q == DRAIN;
    assign test_has_ended = state_q == ENDED;

    always_comb begin
        cnt_a  = cnt_q + {3'b000, acc};
        buf_a  = acc ? buf_q | (30'(item_data) << (ITEM_W * cnt_q)) : buf_q;
        buf_d  = hs ? '0 : buf_a;
        cnt_d  = hs ? '0 : cnt_a;
`ifdef DCT_NO_WRAP_EN
        addr_d = (hs & (addr_q != LAST)) ? addr_q + ADDR_W'(1) : addr_q;
`else
        addr_d = hs ? addr_q + ADDR_W'(1) : addr_q;
`endif
        wrap_d = wrap_q | (hs & (addr_q == LAST));
        case (state_q)
            IDLE:    state_d = end_req ? DRAIN : trc_on ? COLLECT : IDLE;
            COLLECT: state_d = end_req ? DRAIN :
                               ((cnt_a == FULL) | (flush_req & (cnt_a != 4'd0) & !stop)) ? EMIT :
                               !trc_on ? IDLE : COLLECT;
            EMIT:    state_d = end_req ? DRAIN : hs ? COLLECT : EMIT;
            DRAIN:   state_d = (hs | (cnt_q == 4'd0)) ? ENDED : DRAIN;
            default: state_d = ENDED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
        end
    end
endmodule

// File: tb/tb_top_level_nios2_qsys_0_oci_dct_ctrl.sv
// tb_top_level_nios2_qsys_0_oci_dct_ctrl: vector table, corner sequences and random run against a frame-level model
module tb_top_level_nios2_qsys_0_oci_dct_ctrl;
    logic clk = 1'b0, reset_n = 1'b0, trc_on = 1'b0, item_valid = 1'b0;
    logic [9:0] item_data = '0;
    logic flush_req = 1'b0, end_req = 1'b0, frm_ready = 1'b0;
    logic item_ready, frm_valid, wrap, test_ending, test_has_ended;
    logic [29:0] frm_data, dct_buffer;
    logic [6:0] frm_addr;
    logic [3:0] dct_count;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    top_level_nios2_qsys_0_oci_dct_ctrl dut (
        .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .item_valid(item_valid),
        .item_data(item_data), .item_ready(item_ready), .flush_req(flush_req),
        .end_req(end_req), .frm_valid(frm_valid), .frm_data(frm_data),
        .frm_addr(frm_addr), .frm_ready(frm_ready), .wrap(wrap),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended)
    );

    typedef struct {
        int t, v, d, f, e, r;
        int rdy, fv, bf, ad, cn, ing, ed;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        trc_on = 0; item_valid = 0; item_data = 0; flush_req = 0; end_req = 0; frm_ready = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdy"}, 32'(item_ready), 0);
        chk({nm, "_fv"}, 32'(frm_valid), 0);
        chk({nm, "_data"}, 32'(frm_data), 0);
        chk({nm, "_buf"}, 32'(dct_buffer), 0);
        chk({nm, "_addr"}, 32'(frm_addr), 0);
        chk({nm, "_cnt"}, 32'(dct_count), 0);
        chk({nm, "_wrap"}, 32'(wrap), 0);
        chk({nm, "_ing"}, 32'(test_ending), 0);
        chk({nm, "_ed"}, 32'(test_has_ended), 0);
    endtask

    int slot[3];
    int n, addr, k, cyc;
    bit pend, started, wr, stopped;

    initial begin
        //         t  v  d      f  e  r   rdy fv buf          addr cnt ing ed
        tab.push_back('{1, 0, 0,     0, 0, 0,  0, 0, 0,          0, 0, 0, 0});
        tab.push_back('{1, 1, 'h001, 0, 0, 0,  1, 0, 0,          0, 0, 0, 0});
        tab.push_back('{1, 1, 'h002, 0, 0, 0,  1, 0, 'h1,        0, 1, 0, 0});
        tab.push_back('{1, 1, 'h003, 0, 0, 0,  1, 0, 'h801,      0, 2, 0, 0});
        tab.push_back('{1, 0, 0,     0, 0, 1,  0, 1, 'h300801,   0, 3, 0, 0});
        tab.push_back('{1, 0, 0,     0, 0, 0,  1, 0, 0,          1, 0, 0, 0});
        tab.push_back('{1, 1, 'h155, 0, 0, 0,  1, 0, 0,          1, 0, 0, 0});
        tab.push_back('{1, 0, 0,     1, 0, 0,  1, 0, 'h155,      1, 1, 0, 0});
        tab.push_back('{1, 0, 0,     0, 0, 1,  0, 1, 'h155,      1, 1, 0, 0});
        tab.push_back('{1, 0, 0,     1, 0, 0,  1, 0, 0,          2, 0, 0, 0});
        tab.push_back('{1, 0, 0,     0, 0, 0,  1, 0, 0,          2, 0, 0, 0});
        tab.push_back('{1, 1, 'h3ff, 0, 0, 0,  1, 0, 0,          2, 0, 0, 0});
        tab.push_back('{1, 1, 'h200, 0, 0, 0,  1, 0, 'h3ff,      2, 1, 0, 0});
        tab.push_back('{1, 1, 'h0aa, 0, 0, 0,  1, 0, 'h803ff,    2, 2, 0, 0});
        for (int i = 0; i < 5; i++)
            tab.push_back('{1, 1, 'h111, 0, 0, 0,  0, 1, 'h0aa803ff, 2, 3, 0, 0});
        tab.push_back('{1, 0, 0,     0, 0, 1,  0, 1, 'h0aa803ff, 2, 3, 0, 0});
        tab.push_back('{1, 0, 0,     0, 0, 0,  1, 0, 0,          3, 0, 0, 0});
        tab.push_back('{1, 1, 'h011, 0, 0, 0,  1, 0, 0,          3, 0, 0, 0});
        tab.push_back('{1, 1, 'h022, 0, 0, 0,  1, 0, 'h011,      3, 1, 0, 0});
        tab.push_back('{1, 0, 0,     1, 1, 0,  1, 0, 'h8811,     3, 2, 0, 0});
        tab.push_back('{1, 1, 'h033, 0, 0, 0,  0, 1, 'h8811,     3, 2, 1, 0});
        tab.push_back('{1, 0, 0,     0, 0, 1,  0, 1, 'h8811,     3, 2, 1, 0});
        tab.push_back('{1, 1, 'h044, 1, 0, 1,  0, 0, 0,          4, 0, 0, 1});
        tab.push_back('{1, 1, 'h055, 0, 1, 0,  0, 0, 0,          4, 0, 0, 1});

        idle_inputs();
        reset_n = 0;
        tick();
        @(negedge clk);
        chk_zero("reset");
        tick();
        reset_n = 1;

        foreach (tab[i]) begin
            trc_on = tab[i].t[0]; item_valid = tab[i].v[0]; item_data = tab[i].d[9:0];
            flush_req = tab[i].f[0]; end_req = tab[i].e[0]; frm_ready = tab[i].r[0];
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 32'(item_ready), tab[i].rdy);
            chk($sformatf("v%0d_fv", i), 32'(frm_valid), tab[i].fv);
            chk($sformatf("v%0d_data", i), 32'(frm_data), tab[i].bf);
            chk($sformatf("v%0d_buf", i), 32'(dct_buffer), tab[i].bf);
            chk($sformatf("v%0d_addr", i), 32'(frm_addr), tab[i].ad);
            chk($sformatf("v%0d_cnt", i), 32'(dct_count), tab[i].cn);
            chk($sformatf("v%0d_wrap", i), 32'(wrap), 0);
            chk($sformatf("v%0d_ing", i), 32'(test_ending), tab[i].ing);
            chk($sformatf("v%0d_ed", i), 32'(test_has_ended), tab[i].ed);
            tick();
        end

        // reset in the middle of a pending frame
        do_reset();
        trc_on = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            item_valid = 1; item_data = 10'(i + 'h101);
            tick();
        end
        item_valid = 0; frm_ready = 0;
        @(negedge clk);
        chk("rst_pending_fv", 32'(frm_valid), 1);
        reset_n = 0;
        tick();
        @(negedge clk);
        chk_zero("rst_mid");
        reset_n = 1; frm_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("rst_drop_fv", 32'(frm_valid), 0);
            chk("rst_drop_addr", 32'(frm_addr), 0);
        end

        // fill the whole trace memory
        do_reset();
        trc_on = 1; item_valid = 1; frm_ready = 1;
        k = 0; cyc = 0;
`ifdef DCT_NO_WRAP_EN
        while (k < 128 && cyc < 2000) begin
`else
        while (k < 130 && cyc < 2000) begin
`endif
            item_data = 10'($urandom);
            @(negedge clk);
            if (frm_valid && frm_ready) begin
                k++;
                chk($sformatf("fill%0d_addr", k), 32'(frm_addr), (k - 1) % 128);
                chk($sformatf("fill%0d_wrap", k), 32'(wrap), k > 128 ? 1 : 0);
            end
            tick();
            cyc++;
        end
`ifdef DCT_NO_WRAP_EN
        chk("fill_frames", k, 128);
        for (int i = 0; i < 5; i++) begin
            flush_req = i[0];
            @(negedge clk);
            chk("stop_rdy", 32'(item_ready), 0);
            chk("stop_fv", 32'(frm_valid), 0);
            chk("stop_addr", 32'(frm_addr), 127);
            chk("stop_wrap", 32'(wrap), 1);
            tick();
        end
        flush_req = 0; end_req = 1;
        tick();
        end_req = 0;
        @(negedge clk);
        chk("stop_ing", 32'(test_ending), 1);
        tick();
        @(negedge clk);
        chk("stop_ed", 32'(test_has_ended), 1);
        chk("stop_ing_off", 32'(test_ending), 0);
`else
        chk("fill_frames", k, 130);
        @(negedge clk);
        chk("fill_wrap_end", 32'(wrap), 1);
        chk("fill_addr_end", 32'(frm_addr), 2);
`endif

        // random traffic against a frame-level model
        do_reset();
        trc_on = 1;
        n = 0; addr = 0; pend = 0; started = 0; wr = 0; stopped = 0;
        for (int i = 0; i < 3; i++) slot[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            int e_data;
            bit e_rdy;
            item_valid = 1'($urandom_range(0, 1));
            item_data = 10'($urandom);
            flush_req = ($urandom_range(0, 7) == 0);
            frm_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            e_rdy = started && !pend && n < 3 && !stopped;
            e_data = 0;
            for (int j = 0; j < n; j++) e_data += slot[j] * (1 << (10 * j));
            chk("rnd_rdy", 32'(item_ready), 32'(e_rdy));
            chk("rnd_fv", 32'(frm_valid), 32'(pend));
            chk("rnd_data", 32'(frm_data), e_data);
            chk("rnd_cnt", 32'(dct_count), n);
            chk("rnd_addr", 32'(frm_addr), addr);
            chk("rnd_wrap", 32'(wrap), 32'(wr));
            if (item_valid && e_rdy) begin
                slot[n] = int'(item_data);
                n++;
            end
            if (pend) begin
                if (frm_ready) begin
                    pend = 0;
                    n = 0;
                    if (addr == 127) wr = 1;
`ifdef DCT_NO_WRAP_EN
                    addr = addr == 127 ? 127 : addr + 1;
                    stopped = wr;
`else
                    addr = (addr + 1) % 128;
`endif
                end
            end else if (started && !stopped && (n == 3 || (flush_req && n > 0))) begin
                pend = 1;
            end
            started = 1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
